// File: rtl/disp_capture.sv
// ----------------------------------------------------------------------------
// disp_capture
//
// Capture side of a four-digit multiplexed 7-segment display. It samples the
// active-low digit selector and the active-low gfedcba segment bus. Once a
// digit has dwelt long enough to be trusted, it decodes the segment pattern
// back to a 4-bit value and rebuilds the four digit registers.
//
// Parameters
//   STABLE_CNT  consecutive identical samples needed to commit (2..255)
//   CNT_W       width of the stability counter (must hold STABLE_CNT)
//
// Ports
//   CLK         system clock, rising edge
//   RESET       asynchronous, active-high reset
//   selector    active-low one-hot digit enables (1111 = blank)
//   dispDigit   active-low segment bus, bit order gfedcba
//   d0..d3      last committed value per digit
//   valid       bit i set once digit i has been committed since reset
//   frame_done  one-cycle pulse when all four digits have committed
//   seg_err     sticky: an unrecognised pattern reached commit
//   sel_err     sticky: selector was neither one-hot-low nor blank
//
// Build option
//   DISP_CAPTURE_DASH_EN  when defined, dash (0111111) decodes to 4'hF as a
//                         valid digit; otherwise a dash is an unrecognised
//                         pattern.
// ----------------------------------------------------------------------------
module disp_capture #(
    parameter int unsigned STABLE_CNT = 16,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] selector,
    input  logic [6:0] dispDigit,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic [3:0] valid,
    output logic       frame_done,
    output logic       seg_err,
    output logic       sel_err
);

    typedef struct packed {
        logic [3:0] sel;
        logic [6:0] seg;
    } sample_t;

    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CNT);
    localparam logic [CNT_W-1:0] CNT_COMMIT = CNT_W'(STABLE_CNT - 1);

    localparam sample_t SAMPLE_RST = '{sel: 4'b1111, seg: 7'b1111111};

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    function automatic logic is_onehot_low(input logic [3:0] sel);
        return (sel == 4'b1110) || (sel == 4'b1101) ||
               (sel == 4'b1011) || (sel == 4'b0111);
    endfunction

    function automatic logic [1:0] sel_index(input logic [3:0] sel);
        logic [1:0] idx;
        case (sel)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Returns {recognised, value}.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [4:0] dec;
        case (seg)
            7'b1000000: dec = {1'b1, 4'h0};
            7'b1111001: dec = {1'b1, 4'h1};
            7'b0100100: dec = {1'b1, 4'h2};
            7'b0110000: dec = {1'b1, 4'h3};
            7'b0011001: dec = {1'b1, 4'h4};
            7'b0010010: dec = {1'b1, 4'h5};
            7'b0000010: dec = {1'b1, 4'h6};
            7'b1111000: dec = {1'b1, 4'h7};
            7'b0000000: dec = {1'b1, 4'h8};
            7'b0010000: dec = {1'b1, 4'h9};
`ifdef DISP_CAPTURE_DASH_EN
            7'b0111111: dec = {1'b1, 4'hF};
`else
            7'b0111111: dec = 5'b0;
`endif
            default:    dec = 5'b0;
        endcase
        return dec;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    sample_t             s_q, s_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [3:0][3:0]     dig_q, dig_d;
    logic [3:0]          valid_q, valid_d;
    logic [3:0]          mask_q, mask_d;
    logic                frame_done_q, frame_done_d;
    logic                seg_err_q, seg_err_d;
    logic                sel_err_q, sel_err_d;

    sample_t             sample;
    logic                same;
    logic                commit;
    logic [4:0]          dec;
    logic [1:0]          idx;
    logic [3:0]          mask_nxt;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every variable assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        sample       = '{sel: selector, seg: dispDigit};
        same         = (sample == s_q);
        dec          = decode(s_q.seg);
        idx          = sel_index(s_q.sel);
        mask_nxt     = mask_q | (4'(1) << idx);

        s_d          = sample;
        cnt_d        = '0;
        dig_d        = dig_q;
        valid_d      = valid_q;
        mask_d       = mask_q;
        frame_done_d = 1'b0;
        seg_err_d    = seg_err_q;
        // Flag the bad selector on the edge that loads it into s_q.
        sel_err_d    = sel_err_q |
                       (!is_onehot_low(sample.sel) && (sample.sel != 4'b1111));

        // Saturating stability counter; any difference restarts the dwell.
        if (same) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end

        // Fires once per dwell: on the step from STABLE_CNT-1 to STABLE_CNT.
        commit = same && (cnt_q == CNT_COMMIT) && is_onehot_low(s_q.sel);

        if (commit) begin
            if (dec[4]) begin
                dig_d[idx]   = dec[3:0];
                valid_d[idx] = 1'b1;
                if (mask_nxt == 4'b1111) begin
                    frame_done_d = 1'b1;
                    mask_d       = 4'b0000;
                end else begin
                    mask_d       = mask_nxt;
                end
            end else begin
                seg_err_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s_q          <= SAMPLE_RST;
            cnt_q        <= '0;
            dig_q        <= '0;
            valid_q      <= '0;
            mask_q       <= '0;
            frame_done_q <= 1'b0;
            seg_err_q    <= 1'b0;
            sel_err_q    <= 1'b0;
        end else begin
            s_q          <= s_d;
            cnt_q        <= cnt_d;
            dig_q        <= dig_d;
            valid_q      <= valid_d;
            mask_q       <= mask_d;
            frame_done_q <= frame_done_d;
            seg_err_q    <= seg_err_d;
            sel_err_q    <= sel_err_d;
        end
    end

    assign d0         = dig_q[0];
    assign d1         = dig_q[1];
    assign d2         = dig_q[2];
    assign d3         = dig_q[3];
    assign valid      = valid_q;
    assign frame_done = frame_done_q;
    assign seg_err    = seg_err_q;
    assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_disp_capture.sv
// ----------------------------------------------------------------------------
// tb_disp_capture
//
// Directed bench for disp_capture with STABLE_CNT=4. Inputs change 1 time
// unit after a rising edge; outputs are sampled at the same point, well away
// from the next edge.
// ----------------------------------------------------------------------------
module tb_disp_capture;

    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_BAD  = 7'b1010101;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    logic       clk;
    logic       rst;
    logic [3:0] selector;
    logic [6:0] dispDigit;
    logic [3:0] d0, d1, d2, d3;
    logic [3:0] valid;
    logic       frame_done;
    logic       seg_err;
    logic       sel_err;

    int total;
    int bad;
    int fd_count;

    disp_capture #(
        .STABLE_CNT(4),
        .CNT_W     (8)
    ) dut (
        .CLK       (clk),
        .RESET     (rst),
        .selector  (selector),
        .dispDigit (dispDigit),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .valid     (valid),
        .frame_done(frame_done),
        .seg_err   (seg_err),
        .sel_err   (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pins(input logic [3:0] sel, input logic [6:0] seg);
        selector  = sel;
        dispDigit = seg;
    endtask

    // Hold one digit for n edges, counting frame_done pulses on the way.
    task automatic dwell(input logic [3:0] sel, input logic [6:0] seg, input int n);
        pins(sel, seg);
        for (int i = 0; i < n; i++) begin
            step();
            if (frame_done) fd_count++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_d0"},    d0, 0);
        check({tag, "_d1"},    d1, 0);
        check({tag, "_d2"},    d2, 0);
        check({tag, "_d3"},    d3, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_fd"},    frame_done, 0);
        check({tag, "_segerr"}, seg_err, 0);
        check({tag, "_selerr"}, sel_err, 0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        fd_count = 0;
        rst      = 1'b1;
        pins(4'b1111, SEG_OFF);

        // Reset state.
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;

        // Digit 0 shows 3: commit on exactly the 5th edge after settling.
        pins(4'b1110, SEG_3);
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i < 5) begin
                check($sformatf("lat_early_valid_%0d", i), valid, 4'b0000);
                check($sformatf("lat_early_d0_%0d", i), d0, 4'h0);
            end else begin
                check("lat_d0", d0, 4'h3);
                check("lat_valid", valid, 4'b0001);
                check("lat_fd", frame_done, 0);
            end
        end
        step();
        step();

        // Short dwells on digit 1 (3 cycles, then exactly STABLE_CNT cycles).
        fd_count = 0;
        dwell(4'b1101, SEG_7, 3);
        dwell(4'b1111, SEG_OFF, 2);
        dwell(4'b1101, SEG_7, 4);
        dwell(4'b1111, SEG_OFF, 6);
        check("short_d1", d1, 4'h0);
        check("short_valid", valid, 4'b0001);
        check("short_fd", fd_count, 0);
        check("blank_selerr", sel_err, 0);

        // Unrecognised pattern on digit 2: seg_err rises exactly at commit.
        pins(4'b1011, SEG_BAD);
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("segerr_%0d", i), seg_err, (i >= 5) ? 1 : 0);
        end
        check("segerr_d2", d2, 4'h0);
        check("segerr_valid", valid, 4'b0001);

        // Full frame 1,2,3,4; digit 0 already in the mask from the first dwell.
        fd_count = 0;
        dwell(4'b1110, SEG_1, 8);
        dwell(4'b1101, SEG_2, 8);
        dwell(4'b1011, SEG_3, 8);
        check("frame1_fd_early", fd_count, 0);
        check("frame1_d0", d0, 4'h1);
        check("frame1_d1", d1, 4'h2);
        check("frame1_d2", d2, 4'h3);
        pins(4'b0111, SEG_4);
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i < 5) begin
                check($sformatf("frame1_d3_early_%0d", i), d3, 4'h0);
                check($sformatf("frame1_fd_pre_%0d", i), frame_done, 0);
            end else if (i == 5) begin
                check("frame1_d3", d3, 4'h4);
                check("frame1_fd_pulse", frame_done, 1);
                check("frame1_mask_clr", dut.mask_q, 4'b0000);
            end else begin
                check($sformatf("frame1_fd_post_%0d", i), frame_done, 0);
            end
        end
        check("frame1_valid", valid, 4'b1111);
        check("frame1_segerr_sticky", seg_err, 1);

        // Second frame 9,8,8,8: repeated values still separate by selector.
        fd_count = 0;
        dwell(4'b1110, SEG_9, 8);
        dwell(4'b1101, SEG_8, 8);
        dwell(4'b1011, SEG_8, 8);
        check("frame2_fd_early", fd_count, 0);
        dwell(4'b0111, SEG_8, 8);
        check("frame2_fd", fd_count, 1);
        check("frame2_d0", d0, 4'h9);
        check("frame2_d1", d1, 4'h8);
        check("frame2_d2", d2, 4'h8);
        check("frame2_d3", d3, 4'h8);
        check("frame2_segerr", seg_err, 1);
        check("frame2_selerr", sel_err, 0);

        // Non-one-hot selector for one cycle.
        pins(4'b1100, SEG_1);
        step();
        check("selerr_set", sel_err, 1);

        // Mid-dwell reset on digit 3.
        pins(4'b0111, SEG_5);
        step();
        step();
        step();
        check("selerr_no_commit_d0", d0, 4'h9);
        check("selerr_no_commit_d3", d3, 4'h8);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        step();
        step();
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i < 5) begin
                check($sformatf("postrst_valid_%0d", i), valid, 4'b0000);
            end else begin
                check("postrst_d3", d3, 4'h5);
                check("postrst_valid", valid, 4'b1000);
            end
        end
        step();
        step();

        // Dash on digit 0.
        pins(4'b1110, SEG_DASH);
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("dash_pre_segerr_%0d", i), seg_err, 0);
        end
        step();
`ifdef DISP_CAPTURE_DASH_EN
        check("dash_d0", d0, 4'hF);
        check("dash_valid", valid, 4'b1001);
        check("dash_segerr", seg_err, 0);
`else
        check("dash_d0", d0, 4'h0);
        check("dash_valid", valid, 4'b1000);
        check("dash_segerr", seg_err, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/disp_capture.md
# disp_capture

Capture-side counterpart of the four-digit multiplexed 7-segment driver. It samples the active-low digit selector and the active-low gfedcba segment bus, and waits for each digit's dwell to settle. It then decodes the segment pattern back to a 4-bit value and reconstructs all four digit registers. It sits on the display pins in loopback/self-test builds and feeds bench scoreboards and the on-board display checker.

## Interface
- STABLE_CNT, 16: consecutive identical samples required before a digit is committed; legal range 2..255.
- CNT_W, 8: width of the stability counter; must hold STABLE_CNT.
- CLK  input  1  system clock, all state on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- selector  input  4  digit enables, active-low one-hot (1110 = digit 0 … 0111 = digit 3, 1111 = blank).
- dispDigit  input  7  segment bus, active-low, bit order gfedcba.
- d0, d1, d2, d3  output  4 each  last committed value per digit.
- valid  output  4  bit i set once di has been committed since reset.
- frame_done  output  1  one-cycle pulse when all four digits have been committed since the previous pulse.
- seg_err  output  1  sticky; an unrecognised segment pattern reached commit.
- sel_err  output  1  sticky; selector held a value that is neither one-hot-low nor 1111.

## Operation
- Input stage: {selector, dispDigit} registered every cycle into s_reg. Reset value of s_reg is {4'b1111, 7'b1111111}.
- Stability counter cnt:
  - If the incoming sample equals s_reg, cnt increments, saturating at STABLE_CNT.
  - Otherwise cnt clears to 0.
- Commit rule:
  - Commit fires when the incoming sample equals s_reg, cnt == STABLE_CNT-1, and s_reg.selector is one-hot-low.
  - Exactly one commit per dwell. While saturated at STABLE_CNT, no further commit occurs.
- Decode (pattern → value): 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9. Dash 0111111 is governed by Configuration.
- On commit with a valid pattern: d[index] gets the value, and valid[index] and mask[index] are set.
- On commit with an invalid pattern: d, valid and mask are unchanged, and seg_err is set.
- Blank selector (1111): cnt keeps counting but no commit is possible, and it is not an error.
- Non-one-hot selector (e.g. 1100, 0000): sel_err is set on the first cycle s_reg holds it, and no commit occurs.
- Frame tracking:
  - mask[3:0] accumulates committed digits.
  - On the edge where mask would become 4'b1111, frame_done pulses for one cycle and mask clears to 0.
  - A digit re-committed before the frame completes just rewrites d. The frame is not restarted.
- seg_err and sel_err clear only on RESET.

## Timing
- Reset (async assert, sync to CLK on release): d0..d3=0, valid=0, frame_done=0, seg_err=0, sel_err=0, cnt=0, mask=0.
- Commit latency: pins change before edge E0 and then hold. s_reg loads at E0, cnt reaches STABLE_CNT-1 at E(STABLE_CNT-1), and d/valid update at edge E(STABLE_CNT). They are visible STABLE_CNT+1 edges after the pins settle.
- frame_done is asserted in the same cycle as the completing digit's d update.
- Any single-cycle glitch in a dwell resets cnt. A dwell shorter than STABLE_CNT+1 cycles never commits.
- The same value on consecutive digits is still distinguished, because the selector differs, which clears cnt.
- RESET asserted mid-dwell or mid-frame discards cnt, mask and all outputs immediately. The next commit requires a full stable dwell after release.

## Configuration
- DISP_CAPTURE_DASH_EN defined: dash 0111111 decodes to 4'hF as a valid commit; it sets valid/mask and does not set seg_err.
- Undefined: dash is an unrecognised pattern; at commit it sets seg_err and leaves d/valid/mask unchanged.

## Test plan
- Reset with STABLE_CNT=4; drive selector=1110 with the pattern for 3 held. Required: d0=3 and valid=0001 exactly at the 5th edge after the pins settle, with no earlier update.
- Cycle through digits 0..3 showing 1,2,3,4 with 8-cycle dwells. Required: d0..d3=1,2,3,4, one frame_done pulse coincident with the d3 update, and mask cleared afterward.
- Digit 1 dwell of 3 cycles (shorter than STABLE_CNT+1) with the pattern for 7. Required: d1 unchanged, valid[1]=0, no frame_done.
- Segment pattern 1010101 held on digit 2 for 8 cycles. Required: seg_err=1 from the commit edge onward, d2 and valid[2] unchanged, and seg_err stays set through later valid frames.
- selector=1100 for 1 cycle. Required: sel_err=1 and no commit. Then assert RESET mid-dwell on digit 3. Required: all outputs 0 immediately, and a fresh dwell needs a full STABLE_CNT+1 cycles to commit.
- Dash 0111111 on digit 0. Required: with DISP_CAPTURE_DASH_EN, d0=F, valid[0]=1 and seg_err=0. Without it, seg_err=1 and valid[0]=0.
